irq_pend_ctrl: RTL

Pending-request controller that sits directly upstream of the 8-bit priority encoder `pe_8b`. It captures request lines into a pending register and drives the masked pending vector into the encoder's `in`. It takes back the encoder's `val`/`out` and offers the winning index to a consumer over a valid/ready handshake. After acceptance it clears the serviced bit and holds off new offers until the consumer signals completion.

---
 rtl/irq_pend_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/irq_pend_ctrl.sv
// Pending-request controller feeding an external 8-bit priority encoder, offering the winner over valid/ready.
// Define IRQ_EDGE_EN for rising-edge request capture; the default build captures requests by level.
//
// state     | meaning
// S_IDLE    | no offer outstanding; latch encoder result when pe_val is high
// S_OFFER   | irq_valid high, irq_id frozen until irq_ready
// S_SERVICE | serviced bit cleared; wait for irq_done
module irq_pend_ctrl #(
   parameter int W_IN  = 8,
   parameter int W_OUT = $clog2(W_IN)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [W_IN-1:0]  i_req,
   input  logic [W_IN-1:0]  i_mask,
   output logic [W_IN-1:0]  o_pe_in,
   input  logic             i_pe_val,
   input  logic [W_OUT-1:0] i_pe_out,
   output logic             o_irq_valid,
   output logic [W_OUT-1:0] o_irq_id,
   input  logic             i_irq_ready,
   input  logic             i_irq_done,
   output logic [W_IN-1:0]  o_pending,
   output logic             o_busy
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_OFFER   = 2'd1,
      S_SERVICE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [W_IN-1:0]  r_pending;
   logic [W_IN-1:0]  w_set;
   logic [W_IN-1:0]  w_clr;
   logic [W_OUT-1:0] r_irq_id;
   logic             w_hs;

`ifdef IRQ_EDGE_EN
   logic [W_IN-1:0]  r_req_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_req_q <= '0;
      else          r_req_q <= i_req;
   end

   assign w_set = i_req & ~r_req_q;
`else
   assign w_set = i_req;
`endif

   assign w_hs = (r_state == S_OFFER) && i_irq_ready;

   always_comb begin
      w_clr = '0;
      if (w_hs) w_clr[r_irq_id] = 1'b1;
   end

   // Set is OR-ed after the clear so a request landing on the serviced bit survives.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_pending <= '0;
      else          r_pending <= (r_pending & ~w_clr) | w_set;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n)                           r_irq_id <= '0;
      else if (r_state == S_IDLE && i_pe_val) r_irq_id <= i_pe_out;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (i_pe_val)    w_state_nxt = S_OFFER;
         S_OFFER:   if (i_irq_ready) w_state_nxt = S_SERVICE;
         S_SERVICE: if (i_irq_done)  w_state_nxt = S_IDLE;
         default:                    w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_irq_valid = 1'b0;
      o_busy      = 1'b0;
      case (r_state)
         S_OFFER:   begin o_irq_valid = 1'b1; o_busy = 1'b1; end
         S_SERVICE: o_busy = 1'b1;
         default:   ;
      endcase
   end

   assign o_irq_id  = r_irq_id;
   assign o_pending = r_pending;
   assign o_pe_in   = r_pending & i_mask;

endmodule
